// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM states,
// wait counter width and the captured request record.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit word: store byte enables and merged word,
// load extraction/extension and misalignment flag (DMEM_ALIGN_CHECK_EN).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data,
    output logic        misaligned
);

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [1:0]  lane;
    logic [31:0] repl;
    logic [31:0] sh;
    logic        sign_b;
    logic        sign_h;

    always_comb begin
        is_byte = (size == SIZE_B);
        is_half = (size == SIZE_H);
        is_word = (size == SIZE_W) || (size == 2'b11);

`ifdef DMEM_ALIGN_CHECK_EN
        misaligned = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
        lane       = addr_lo;
`else
        // Without checking, drop the low bits to the natural boundary.
        misaligned = 1'b0;
        lane       = is_word ? 2'b00 : (is_half ? {addr_lo[1], 1'b0} : addr_lo);
`endif

        if (misaligned)   byte_en = 4'b0000;
        else if (is_word) byte_en = 4'b1111;
        else if (is_half) byte_en = 4'b0011 << lane;
        else              byte_en = 4'b0001 << lane;

        if (is_word)      repl = wdata;
        else if (is_half) repl = {2{wdata[15:0]}};
        else              repl = {4{wdata[7:0]}};

        wr_word = word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) wr_word[8*b +: 8] = repl[8*b +: 8];
        end

        sh     = word >> {lane, 3'b000};
        sign_b = !is_unsigned && sh[7];
        sign_h = !is_unsigned && sh[15];
        if (misaligned)   rd_data = '0;
        else if (is_byte) rd_data = {{24{sign_b}}, sh[7:0]};
        else if (is_half) rd_data = {{16{sign_h}}, sh[15:0]};
        else              rd_data = word;
    end

endmodule

// File: rtl/dmem_unit.sv
// MEM-stage data memory: byte/half/word access behind ready/valid with
// WAIT_CYCLES wait states; misalignment checking under DMEM_ALIGN_CHECK_EN.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        resp_error
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    req_t                   req_q, req_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [31:0]            read_data_q, read_data_d;
    logic                   resp_error_q, resp_error_d;

    req_t                   live_req;
    req_t                   acc;
    logic                   use_cap;
    logic                   do_access;
    logic                   mem_we;
    logic [IDX_W-1:0]       acc_idx;
    logic [DEPTH-1:0][31:0] mem_w;
    logic [3:0]             byte_en;
    logic [31:0]            wr_word;
    logic [31:0]            ld_data;
    logic                   misaligned;
    logic                   unused_addr_hi;

    always_comb begin
        live_req = '{write: req_write, size: req_size, is_unsigned: req_unsigned,
                     addr: address, wdata: write_data};
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        use_cap   = 1'b0;
        do_access = 1'b0;
        req_ready = (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        req_d   = live_req;
                    end
                end
            end
            ST_WAIT: begin
                use_cap = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    do_access = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Zero-wait accesses use the live inputs at the acceptance edge.
        acc     = use_cap ? req_q : live_req;
        acc_idx = acc.addr[IDX_W+1:2];
        mem_we  = do_access && acc.write;

        resp_valid_d = do_access;
        read_data_d  = (do_access && !acc.write) ? ld_data : '0;
        resp_error_d = do_access && misaligned;
    end

    assign unused_addr_hi = ^acc.addr[31:IDX_W+2];

    dmem_lane_align u_align (
        .size        (acc.size),
        .addr_lo     (acc.addr[1:0]),
        .is_unsigned (acc.is_unsigned),
        .wdata       (acc.wdata),
        .word        (mem_w[acc_idx]),
        .byte_en     (byte_en),
        .wr_word     (wr_word),
        .rd_data     (ld_data),
        .misaligned  (misaligned)
    );

    // Memory words power up holding their own index and are never reset;
    // a write edge that coincides with reset is suppressed.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [31:0] word_q = 32'(i);
        logic [31:0] word_d;

        always_comb begin
            word_d = word_q;
            if (mem_we && (acc_idx == IDX_W'(i)) && (byte_en != 4'b0000)) word_d = wr_word;
        end

        always_ff @(posedge clk) begin
            if (!reset) word_q <= word_d;
        end

        assign mem_w[i] = word_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            read_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            read_data_q  <= read_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign read_data  = read_data_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: three instances (0, 2, 3 wait states) against a
// byte-array reference model; directed plan cases plus random traffic.
module tb_dmem_unit;

    localparam int NU = 3;
    localparam int WC [NU] = '{0, 2, 3};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv   [NU];
    logic        rw   [NU];
    logic [1:0]  rs   [NU];
    logic        run  [NU];
    logic [31:0] ra   [NU];
    logic [31:0] wd   [NU];
    logic        rdy  [NU];
    logic        vld  [NU];
    logic [31:0] rd   [NU];
    logic        err  [NU];

    logic [7:0]  mem  [NU][32];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        dmem_unit #(.DEPTH(8), .WAIT_CYCLES(WC[g])) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (rv[g]),
            .req_write    (rw[g]),
            .req_size     (rs[g]),
            .req_unsigned (run[g]),
            .address      (ra[g]),
            .write_data   (wd[g]),
            .req_ready    (rdy[g]),
            .resp_valid   (vld[g]),
            .read_data    (rd[g]),
            .resp_error   (err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: memory as 32 bytes, address taken modulo 32.
    task automatic model(input int u, input logic w, input logic [1:0] s, input logic un,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] er, output logic ee);
        int n, off, base;
        n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        off  = int'(a[1:0]);
        base = int'(a[4:2]) * 4;
        ee   = 1'b0;
        er   = '0;
`ifdef DMEM_ALIGN_CHECK_EN
        ee = (off % n) != 0;
`else
        off = off - (off % n);
`endif
        if (!ee) begin
            if (w) begin
                for (int b = 0; b < n; b++) mem[u][base + off + b] = d[8*b +: 8];
            end else begin
                for (int b = 0; b < n; b++) er[8*b +: 8] = mem[u][base + off + b];
                if (!un && n < 4 && er[8*n-1])
                    for (int b = n; b < 4; b++) er[8*b +: 8] = 8'hFF;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where the response is visible.
    task automatic do_req(input int u, input logic w, input logic [1:0] s, input logic un,
                          input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
        logic [31:0] e_rd;
        logic        e_err;
        rv[u] = 1'b1; rw[u] = w; rs[u] = s; run[u] = un; ra[u] = a; wd[u] = d;
        #1 chk("ready_at_issue", 32'(rdy[u]), 32'd1);
        model(u, w, s, un, a, d, e_rd, e_err);
        @(posedge clk);
        #1;
        if (WC[u] > 0) begin
            rv[u] = 1'($urandom); rw[u] = 1'($urandom); rs[u] = 2'($urandom);
            run[u] = 1'($urandom); ra[u] = $urandom; wd[u] = $urandom;
        end else begin
            rv[u] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < WC[u]; i++) begin
            chk("busy_ready", 32'(rdy[u]), 32'd0);
            chk("busy_valid", 32'(vld[u]), 32'd0);
            chk("busy_rdata", rd[u], 32'd0);
            @(negedge clk);
        end
        chk("resp_valid", 32'(vld[u]), 32'd1);
        chk("resp_rdata", rd[u], e_rd);
        chk("resp_error", 32'(err[u]), 32'(e_err));
        chk("ready_at_resp", 32'(rdy[u]), 32'd1);
        got = rd[u];
        rv[u] = 1'b0;
    endtask

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(vld[u]), 32'd0);
            chk("idle_rdata", rd[u], 32'd0);
            chk("idle_error", 32'(err[u]), 32'd0);
        end
    endtask

    // Accept a word store, then assert reset n_neg negedges after acceptance.
    task automatic store_then_reset(input int u, input int n_neg, input logic [31:0] a,
                                    input logic [31:0] d);
        rv[u] = 1'b1; rw[u] = 1'b1; rs[u] = 2'd2; run[u] = 1'b0; ra[u] = a; wd[u] = d;
        @(posedge clk);
        #1 rv[u] = 1'b0;
        repeat (n_neg) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_async_ready", 32'(rdy[u]), 32'd1);
        chk("rst_async_valid", 32'(vld[u]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(u, 5);
    endtask

    initial begin
        logic [31:0] got;
        for (int u = 0; u < NU; u++) begin
            rv[u] = 1'b0; rw[u] = 1'b0; rs[u] = 2'd0; run[u] = 1'b0; ra[u] = '0; wd[u] = '0;
            for (int i = 0; i < 32; i++) mem[u][i] = ((i % 4) == 0) ? 8'(i / 4) : 8'h00;
        end

        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk("reset_ready", 32'(rdy[u]), 32'd1);
            chk("reset_valid", 32'(vld[u]), 32'd0);
            chk("reset_rdata", rd[u], 32'd0);
            chk("reset_error", 32'(err[u]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // zero-wait directed cases
        do_req(0, 0, 2'd2, 0, 32'h0C, 0, got);           chk("plan_lw_0c", got, 32'h3);
        do_req(0, 1, 2'd0, 0, 32'h11, 32'h0000_0080, got); chk("plan_sb_rd", got, 32'h0);
        do_req(0, 0, 2'd0, 0, 32'h11, 0, got);           chk("plan_lb_s", got, 32'hFFFF_FF80);
        do_req(0, 0, 2'd0, 1, 32'h11, 0, got);           chk("plan_lbu", got, 32'h0000_0080);
        do_req(0, 0, 2'd2, 0, 32'h10, 0, got);           chk("plan_lw_10", got, 32'h0000_8004);
        do_req(0, 0, 2'd2, 0, 32'h20, 0, got);           chk("plan_wrap", got, 32'h0);
        do_req(0, 1, 2'd1, 0, 32'h1A, 32'h1234_BEEF, got);
        do_req(0, 0, 2'd2, 0, 32'h18, 0, got);           chk("plan_sh_lw", got, 32'hBEEF_0006);
        do_req(0, 0, 2'd1, 0, 32'h1A, 0, got);           chk("plan_lh_s", got, 32'hFFFF_BEEF);
        do_req(0, 0, 2'd3, 1, 32'h18, 0, got);           chk("plan_size3", got, 32'hBEEF_0006);
        do_req(0, 0, 2'd2, 0, 32'h06, 0, got);
        do_req(0, 1, 2'd2, 0, 32'h06, 32'h1234_5678, got);
        do_req(0, 0, 2'd2, 0, 32'h04, 0, got);
        do_req(0, 0, 2'd2, 0, 32'h08, 0, got);
        do_req(0, 0, 2'd1, 1, 32'h07, 0, got);
        idle(0, 2);

        // wait states, back-to-back
        do_req(1, 0, 2'd2, 0, 32'h0C, 0, got);           chk("plan_w2_lw", got, 32'h3);
        do_req(1, 1, 2'd0, 0, 32'h0D, 32'h0000_00A5, got);
        do_req(1, 0, 2'd2, 0, 32'h0C, 0, got);           chk("plan_w2_raw", got, 32'h0000_A503);
        idle(1, 2);

        // reset dropping a pending store, mid-wait and just before its access edge
        @(negedge clk);
        store_then_reset(2, 2, 32'h04, 32'hDEAD_BEEF);
        do_req(2, 0, 2'd2, 0, 32'h04, 0, got);           chk("plan_rst_w3", got, 32'h1);
        store_then_reset(2, 3, 32'h08, 32'hCAFE_F00D);
        do_req(2, 0, 2'd2, 0, 32'h08, 0, got);           chk("rst_at_access", got, 32'h2);

        for (int u = 0; u < NU; u++) begin
            for (int k = 0; k < 120; k++) begin
                do_req(u, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, got);
                if ($urandom_range(3) == 0) idle(u, $urandom_range(2));
            end
            for (int i = 0; i < 8; i++) do_req(u, 0, 2'd2, 0, 32'(i * 4), 0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
